// File: rtl/frame_write_sched.sv
// rtl/frame_write_sched.sv - frame FIFO read scheduler issuing SSD write commands and streaming frames
// Optional sync-word / frame-counter checker enabled by defining FRAME_CHECK_EN.
module frame_write_sched #(
    parameter int unsigned FRAME_BYTES    = 1024,
    parameter int unsigned SECT_PER_FRAME = 2,
    parameter logic [31:0] START_LBA      = 32'd0,
    parameter logic [31:0] END_LBA        = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        enable,
    input  logic [14:0] rdusedw,
    output logic        fifo_rdreq,
    input  logic [7:0]  fifo_q,
    output logic        cmd_req,
    output logic [31:0] cmd_lba,
    output logic [7:0]  cmd_cnt,
    input  logic        cmd_ack,
    input  logic        wr_ready,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    output logic        frame_done,
    output logic [31:0] frame_cnt,
    output logic        busy,
    output logic        sync_err,
    output logic [15:0] err_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_STREAM, S_DRAIN, S_DONE} state_t;

    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam logic [CW-1:0] FB      = CW'(FRAME_BYTES);
    localparam logic [CW-1:0] FB_LAST = CW'(FRAME_BYTES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] rd_cnt;
    logic          primed;
    logic [32:0]   lba_end;
    logic          lba_wrap;

    assign cmd_cnt  = 8'(SECT_PER_FRAME);
    assign wr_data  = fifo_q;
    assign lba_end  = {1'b0, cmd_lba} + 33'(2 * SECT_PER_FRAME) - 33'd1;
    assign lba_wrap = lba_end > {1'b0, END_LBA};

    always_comb begin
        state_nxt  = state;
        cmd_req    = 1'b0;
        fifo_rdreq = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && ({17'd0, rdusedw} >= FRAME_BYTES))
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                cmd_req = 1'b1;
                if (cmd_ack)
                    state_nxt = S_STREAM;
            end
            S_STREAM: begin
                // first STREAM cycle is spent letting the accepted command settle
                fifo_rdreq = primed && wr_ready && (rd_cnt < FB);
                if (fifo_rdreq && (rd_cnt == FB_LAST))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= S_IDLE;
            rd_cnt    <= '0;
            primed    <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            frame_cnt <= 32'd0;
            cmd_lba   <= START_LBA;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != S_IDLE);
            wr_valid <= fifo_rdreq;
            primed   <= (state == S_STREAM);
            if (state == S_IDLE)
                rd_cnt <= '0;
            else if (fifo_rdreq)
                rd_cnt <= rd_cnt + 1'b1;
            if (state == S_DONE) begin
                frame_cnt <= frame_cnt + 32'd1;
                cmd_lba   <= lba_wrap ? START_LBA : cmd_lba + 32'(SECT_PER_FRAME);
            end
        end
    end

`ifdef FRAME_CHECK_EN
    logic [3:0]  beat_idx;
    logic [23:0] cnt_hi;
    logic [31:0] exp_cnt;
    logic [31:0] rx_cnt;
    logic        have_exp;
    logic        frame_bad;
    logic [7:0]  sync_byte;

    assign rx_cnt = {cnt_hi, fifo_q};

    always_comb begin
        sync_byte = 8'h1D;
        case (beat_idx[1:0])
            2'd0:    sync_byte = 8'h1A;
            2'd1:    sync_byte = 8'hCF;
            2'd2:    sync_byte = 8'hFC;
            default: sync_byte = 8'h1D;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            beat_idx  <= 4'd0;
            cnt_hi    <= 24'd0;
            exp_cnt   <= 32'd0;
            have_exp  <= 1'b0;
            frame_bad <= 1'b0;
            sync_err  <= 1'b0;
            err_cnt   <= 16'd0;
        end else begin
            if (state == S_IDLE)
                beat_idx <= 4'd0;
            else if (wr_valid && (beat_idx < 4'd8))
                beat_idx <= beat_idx + 4'd1;
            if (wr_valid && (beat_idx < 4'd4) && (fifo_q != sync_byte))
                frame_bad <= 1'b1;
            if (wr_valid && (beat_idx >= 4'd4) && (beat_idx < 4'd7))
                cnt_hi <= {cnt_hi[15:0], fifo_q};
            // match, first load and resync all continue from the received value
            if (wr_valid && (beat_idx == 4'd7)) begin
                if (have_exp && (rx_cnt != exp_cnt))
                    frame_bad <= 1'b1;
                exp_cnt  <= rx_cnt + 32'd1;
                have_exp <= 1'b1;
            end
            if (state == S_DONE) begin
                frame_bad <= 1'b0;
                if (frame_bad) begin
                    sync_err <= 1'b1;
                    if (err_cnt != 16'hFFFF)
                        err_cnt <= err_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign sync_err = 1'b0;
    assign err_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_frame_write_sched.sv
// tb/tb_frame_write_sched.sv - scoreboard bench for frame_write_sched (LBA window 100..105)
module tb_frame_write_sched;
    logic        clk = 1'b0;
    logic        nRST;
    logic        enable;
    logic [14:0] rdusedw;
    logic        fifo_rdreq;
    logic [7:0]  fifo_q;
    logic        cmd_req;
    logic [31:0] cmd_lba;
    logic [7:0]  cmd_cnt;
    logic        cmd_ack;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        frame_done;
    logic [31:0] frame_cnt;
    logic        busy;
    logic        sync_err;
    logic [15:0] err_cnt;

`ifdef FRAME_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    frame_write_sched #(
        .FRAME_BYTES(1024), .SECT_PER_FRAME(2),
        .START_LBA(32'd100), .END_LBA(32'd105)
    ) dut (
        .clk(clk), .nRST(nRST), .enable(enable), .rdusedw(rdusedw),
        .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q),
        .cmd_req(cmd_req), .cmd_lba(cmd_lba), .cmd_cnt(cmd_cnt), .cmd_ack(cmd_ack),
        .wr_ready(wr_ready), .wr_data(wr_data), .wr_valid(wr_valid),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy),
        .sync_err(sync_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0]  fifo_mem [0:4095];
    logic [11:0] wr_ptr = 12'd0;
    logic [11:0] rd_ptr = 12'd0;
    logic        flush;
    logic [7:0]  exp_q [$];

    always @(posedge clk) begin
        if (flush)
            rd_ptr <= wr_ptr;
        else if (fifo_rdreq) begin
            fifo_q <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 12'd1;
        end
    end

    int checks = 0;
    int errors = 0;
    int beats, first_cyc, last_cyc, done_cyc, ndone;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [31:0] c, input int i);
        logic [31:0] iv;
        iv = i;
        case (i)
            0: return 8'h1A;
            1: return 8'hCF;
            2: return 8'hFC;
            3: return 8'h1D;
            4: return c[31:24];
            5: return c[23:16];
            6: return c[15:8];
            7: return c[7:0];
            default: return iv[7:0];
        endcase
    endfunction

    task automatic load_frame(input logic [31:0] c, input int first, input int last);
        for (int i = first; i < last; i++) begin
            fifo_mem[wr_ptr] = fbyte(c, i);
            wr_ptr = wr_ptr + 12'd1;
            exp_q.push_back(fbyte(c, i));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_req"}, cmd_req, 0);
        check({tag, "_rdreq"}, fifo_rdreq, 0);
        check({tag, "_wr_valid"}, wr_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_cmd_lba"}, cmd_lba, 100);
        check({tag, "_cmd_cnt"}, cmd_cnt, 2);
        check({tag, "_sync_err"}, sync_err, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    // expects rdusedw to have just reached a full frame in IDLE
    task automatic run_frame(input int ack_delay, input bit toggle, input int abort_at,
                             input logic [31:0] exp_lba);
        int cyc;
        @(posedge clk);
        @(negedge clk);
        check("cmd_req_rise", cmd_req, 1);
        check("cmd_lba_req", cmd_lba, exp_lba);
        check("cmd_cnt_req", cmd_cnt, 2);
        check("busy_req", busy, 1);
        enable = 1'b0;
        rdusedw = 15'd0;
        wr_ready = 1'b1;
        repeat (ack_delay) @(negedge clk);
        check("cmd_req_hold", cmd_req, 1);
        cmd_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_ack = 1'b0;
        cyc = 1;
        check("cmd_req_drop", cmd_req, 0);
        check("rdreq_gap", fifo_rdreq, 0);
        beats = 0; first_cyc = 0; last_cyc = 0; done_cyc = 0; ndone = 0;
        while (cyc < 4000) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (wr_valid) begin
                if (first_cyc == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats++;
                if (exp_q.size() == 0)
                    check("sb_empty", 1, 0);
                else
                    check("wr_data", wr_data, exp_q.pop_front());
            end
            if (frame_done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (abort_at != 0 && beats == abort_at) begin
                nRST = 1'b0;
                #1;
                check_reset_vals("abort");
                @(negedge clk);
                nRST = 1'b1;
                flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
                exp_q.delete();
                return;
            end
            if (!busy) break;
            if (toggle) wr_ready = ((cyc / 3) % 2 == 0);
        end
        check("frame_end_idle", busy, 0);
        check("beats", beats, 1024);
        check("done_pulses", ndone, 1);
        check("sb_left", exp_q.size(), 0);
    endtask

    initial begin
        nRST = 1'b0; enable = 1'b0; rdusedw = 15'd0; cmd_ack = 1'b0;
        wr_ready = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        nRST = 1'b1;
        @(negedge clk);
        check_reset_vals("post_rst");

        // frame 1: one byte short holds off the command
        load_frame(32'd0, 0, 1023);
        rdusedw = 15'd1023;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("short_no_req", cmd_req, 0);
        check("short_busy", busy, 0);
        load_frame(32'd0, 1023, 1024);
        rdusedw = 15'd1024;
        run_frame(5, 1'b0, 0, 32'd100);
        check("f1_first_beat", first_cyc, 3);
        check("f1_contiguous", last_cyc - first_cyc, 1023);
        check("f1_latency", done_cyc, 1027);
        check("f1_frame_cnt", frame_cnt, 1);
        check("f1_next_lba", cmd_lba, 102);
        check("f1_sync_err", sync_err, 0);

        // frame 2: back-pressure toggling every 3 cycles
        load_frame(32'd1, 0, 1024);
        enable = 1'b1;
        rdusedw = 15'd1024;
        run_frame(2, 1'b1, 0, 32'd102);
        check("f2_frame_cnt", frame_cnt, 2);
        check("f2_next_lba", cmd_lba, 104);
        check("f2_sync_err", sync_err, 0);

        // frame 3: counter skips 2, LBA wraps after it
        load_frame(32'd3, 0, 1024);
        enable = 1'b1;
        rdusedw = 15'd1024;
        run_frame(0, 1'b0, 0, 32'd104);
        check("f3_frame_cnt", frame_cnt, 3);
        check("f3_wrap_lba", cmd_lba, 100);
        check("f3_sync_err", sync_err, EXP_ERR);
        check("f3_err_cnt", err_cnt, EXP_ERR);

        // frame 4: reset at byte 500
        load_frame(32'd4, 0, 1024);
        enable = 1'b1;
        rdusedw = 15'd1024;
        run_frame(1, 1'b0, 500, 32'd100);
        @(negedge clk);
        check_reset_vals("after_abort");

        // frame 5: clean restart
        load_frame(32'd5, 0, 1024);
        enable = 1'b1;
        rdusedw = 15'd1024;
        run_frame(3, 1'b0, 0, 32'd100);
        check("f5_latency", done_cyc, 1027);
        check("f5_frame_cnt", frame_cnt, 1);
        check("f5_next_lba", cmd_lba, 102);
        check("f5_sync_err", sync_err, 0);
        check("f5_err_cnt", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
